// File: rtl/fft8_pkg.sv
// fft8_pkg: shared widths and slot addressing for the 8-point FFT pipeline.
package fft8_pkg;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int CW = $clog2(N);

    localparam logic [CW:0] LAST_SLOT = (CW + 1)'(N - 1);

    function automatic int slot_lsb(input int k);
        return k * DW;
    endfunction

endpackage

// File: rtl/fft8_bank.sv
// fft8_bank: N x DW sample register file with single write port and flat read bus.
module fft8_bank
    import fft8_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_we,
    input  logic [CW-1:0]   i_addr,
    input  logic [DW-1:0]   i_data,
    output logic [N*DW-1:0] o_rd
);

    logic [DW-1:0] r_mem [N];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N; k++) r_mem[k] <= '0;
        end else if (i_we) begin
            r_mem[i_addr] <= i_data;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_rd
        assign o_rd[slot_lsb(k) +: DW] = r_mem[k];
    end

endmodule

// File: rtl/fft8_sample_loader.sv
// fft8_sample_loader: packs a valid/ready sample stream into ping-pong 8-sample
// frames presented in parallel to the FFT core.
module fft8_sample_loader
    import fft8_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_s_valid,
    output logic            o_s_ready,
    input  logic [DW-1:0]   i_s_data,
    input  logic            i_flush,
    output logic            o_frame_valid,
    output logic            o_start,
    output logic [N*DW-1:0] o_frame_data,
    input  logic            i_frame_ack,
    output logic [CW:0]     o_wr_count
);

    logic [1:0]      r_full;
    logic            r_wr_sel;
    logic            r_rd_sel;
    logic [CW:0]     r_wr_cnt;
    logic            r_rst_q;
    logic            r_fv_q;
    logic            r_ack_q;

    logic            w_acc;
    logic            w_wr;
    logic            w_done;
    logic            w_rel;
    logic [1:0]      w_full_nxt;
    logic [CW:0]     w_cnt_nxt;
    logic [N*DW-1:0] w_bank [2];

    assign o_s_ready     = r_rst_q & ~r_full[r_wr_sel];
    assign o_frame_valid = r_full[r_rd_sel];
    assign o_wr_count    = r_wr_cnt;
    assign w_acc         = i_s_valid & o_s_ready;
    assign w_wr          = w_acc & ~i_flush;
    assign w_done        = w_wr & (r_wr_cnt == LAST_SLOT);
    assign w_rel         = o_frame_valid & i_frame_ack;
    // A new frame either rises out of idle or directly follows a released one.
    assign o_start       = o_frame_valid & (~r_fv_q | r_ack_q);
    assign o_frame_data  = o_frame_valid ? w_bank[r_rd_sel] : '0;

    // Completion and release always target different banks, so both may apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_done) w_full_nxt[r_wr_sel] = 1'b1;
        if (w_rel) w_full_nxt[r_rd_sel] = 1'b0;
        w_cnt_nxt = i_flush ? '0 : w_done ? '0 : w_acc ? r_wr_cnt + 1'b1 : r_wr_cnt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_full   <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_wr_cnt <= '0;
            r_rst_q  <= 1'b0;
            r_fv_q   <= 1'b0;
            r_ack_q  <= 1'b0;
        end else begin
            r_full   <= w_full_nxt;
            r_wr_sel <= r_wr_sel ^ w_done;
            r_rd_sel <= r_rd_sel ^ w_rel;
            r_wr_cnt <= w_cnt_nxt;
            r_rst_q  <= 1'b1;
            r_fv_q   <= o_frame_valid;
            r_ack_q  <= w_rel;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft8_bank u_bank (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_we    (w_wr && (r_wr_sel == 1'(b))),
            .i_addr  (r_wr_cnt[CW-1:0]),
            .i_data  (i_s_data),
            .o_rd    (w_bank[b])
        );
    end

endmodule

// File: tb/tb_fft8_sample_loader.sv
// tb_fft8_sample_loader: directed stimulus with a frame scoreboard checked by
// an independent monitor on every start pulse and every held cycle.
module tb_fft8_sample_loader;
    import fft8_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_data = '0;
    logic            flush = 1'b0;
    logic            frame_valid;
    logic            start;
    logic [N*DW-1:0] frame_data;
    logic            frame_ack;
    logic [CW:0]     wr_count;
    logic            man_ack = 1'b0;
    logic            auto_ack = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    logic [N*DW-1:0] exp_q [$];
    logic [N*DW-1:0] held = '0;

    always #5 clk = ~clk;

    assign frame_ack = man_ack | (auto_ack & start);

    fft8_sample_loader dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_s_valid     (s_valid),
        .o_s_ready     (s_ready),
        .i_s_data      (s_data),
        .i_flush       (flush),
        .o_frame_valid (frame_valid),
        .o_start       (start),
        .o_frame_data  (frame_data),
        .i_frame_ack   (frame_ack),
        .o_wr_count    (wr_count)
    );

    task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] ramp(input int base);
        logic [N*DW-1:0] f;
        for (int k = 0; k < N; k++) f[slot_lsb(k) +: DW] = DW'(base + k);
        return f;
    endfunction

    // Monitor: pop on each start, otherwise demand an unchanged frame.
    always @(negedge clk) begin
        if (start === 1'b1 && frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", frame_data, '0);
                if (frame_data === '0) begin
                    n_mis++;
                    $display("FAIL unexpected_start: got start=1 expected no frame pending");
                end
            end else begin
                check("frame_data", frame_data, exp_q.pop_front());
            end
            held = frame_data;
        end else if (frame_valid === 1'b1) begin
            check("frame_stable", frame_data, held);
        end else if (start === 1'b1) begin
            check("start_without_valid", {127'b0, start}, '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        int t = 0;
        s_valid = 1'b1;
        s_data = DW'(v);
        while (s_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_mis++;
            $display("FAIL send_timeout: got s_ready=0 for 50 cycles expected acceptance of %0d", v);
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int base);
        for (int k = 0; k < N; k++) send(base + k);
    endtask

    task automatic ack_once();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
    endtask

    initial begin
        // 1: reset held 3 cycles with s_valid asserted
        s_valid = 1'b1;
        s_data = 16'hdead;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_frame_valid", {127'b0, frame_valid}, '0);
            check("rst_start", {127'b0, start}, '0);
            check("rst_wr_count", {124'b0, wr_count}, '0);
            check("rst_s_ready", {127'b0, s_ready}, '0);
            check("rst_frame_data", frame_data, '0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_s_ready", {127'b0, s_ready}, 128'd1);
        s_valid = 1'b0;
        tick();
        check("post_rst_wr_count", {124'b0, wr_count}, '0);

        // 2: single frame 1..8, no ack
        send_frame(1);
        exp_q.push_back(128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("f1_valid", {127'b0, frame_valid}, 128'd1);
        tick();
        tick();
        check("f1_start_once", {127'b0, start}, '0);

        // 3: backpressure with both banks full
        send_frame(9);
        exp_q.push_back(ramp(9));
        check("bp_s_ready", {127'b0, s_ready}, '0);
        s_valid = 1'b1;
        s_data = 16'd17;
        tick();
        tick();
        tick();
        check("bp_held_wr_count", {124'b0, wr_count}, '0);
        check("bp_still_not_ready", {127'b0, s_ready}, '0);
        ack_once();
        s_valid = 1'b0;
        check("bp_ready_after_ack", {127'b0, s_ready}, 128'd1);
        check("bp_valid_after_ack", {127'b0, frame_valid}, 128'd1);
        check("bp_start_after_ack", {127'b0, start}, 128'd1);
        tick();
        check("bp_17_not_taken", {124'b0, wr_count}, '0);
        ack_once();
        check("bp_drained", {127'b0, frame_valid}, '0);

        // 4: continuous stream 0..63, ack on every start
        auto_ack = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N; k++) begin
                check("stream_s_ready", {127'b0, s_ready}, 128'd1);
                send(f * N + k);
            end
            exp_q.push_back(ramp(f * N));
        end
        tick();
        tick();
        auto_ack = 1'b0;
        check("stream_idle", {127'b0, frame_valid}, '0);
        check("stream_all_seen", 128'(exp_q.size()), '0);

        // 5: ack on the same edge as the completing sample of the next frame
        send_frame(300);
        exp_q.push_back(ramp(300));
        for (int k = 0; k < N - 1; k++) send(310 + k);
        man_ack = 1'b1;
        send(317);
        man_ack = 1'b0;
        exp_q.push_back(ramp(310));
        check("edge_valid", {127'b0, frame_valid}, 128'd1);
        check("edge_s_ready", {127'b0, s_ready}, 128'd1);
        check("edge_start", {127'b0, start}, 128'd1);
        check("edge_wr_count", {124'b0, wr_count}, '0);
        tick();
        ack_once();

        // 6a: flush a partial bank, including a sample accepted alongside it
        for (int k = 0; k < 5; k++) send(400 + k);
        check("pre_flush_count", {124'b0, wr_count}, 128'd5);
        flush = 1'b1;
        send(405);
        flush = 1'b0;
        check("flush_count", {124'b0, wr_count}, '0);
        send_frame(500);
        exp_q.push_back(ramp(500));
        tick();

        // 6b: reset mid-frame discards both the partial bank and the held frame
        for (int k = 0; k < 5; k++) send(600 + k);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", {127'b0, frame_valid}, '0);
        check("mid_rst_count", {124'b0, wr_count}, '0);
        check("mid_rst_data", frame_data, '0);
        check("mid_rst_s_ready", {127'b0, s_ready}, '0);
        send_frame(700);
        exp_q.push_back(ramp(700));
        tick();
        ack_once();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("final_queue_empty", 128'(exp_q.size()), '0);
        check("final_idle", {127'b0, frame_valid}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
